// File: rtl/y_demux_pkg.sv
// Shared constants and types for the y_demux4_router slice.
package y_demux_pkg;
  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;
  localparam int CNT_W     = 16;

  typedef logic [SEL_W-1:0] lane_sel_t;
endpackage

// File: rtl/y_demux4_router_y_out_slot.sv
// One-entry valid/ready holding slot for a single router lane.
// Optional handshake counter is enabled by macro Y_DEMUX_COUNT_EN.
module y_out_slot #(
  parameter int SIZE  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [SIZE-1:0] din,
  input  logic            ready,
  output logic            valid,
  output logic [SIZE-1:0] data
`ifdef Y_DEMUX_COUNT_EN
  ,output logic [CNT_W-1:0] cnt
`endif
);

  // A load on the same edge as a drain wins, so a streaming lane never bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

`ifdef Y_DEMUX_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (valid && ready) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/y_demux4_router.sv
// Registered 1-to-4 valid/ready demultiplexer with a holding slot per lane.
// Define Y_DEMUX_COUNT_EN to add per-lane sink handshake counters (port cnt).
module y_demux4_router
  import y_demux_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SIZE-1:0]           in_data,
  input  lane_sel_t                 in_sel,
  output logic [NUM_LANES-1:0]      out_valid,
  input  logic [NUM_LANES-1:0]      out_ready,
  output logic [NUM_LANES*SIZE-1:0] out_data
`ifdef Y_DEMUX_COUNT_EN
  ,output logic [NUM_LANES*CNT_W-1:0] cnt
`endif
);

  logic                 accept;
  logic [NUM_LANES-1:0] load;

  // Only the targeted lane can stall the source.
  always_comb begin
    in_ready = !reset && (!out_valid[in_sel] || out_ready[in_sel]);
    accept   = in_valid && in_ready;
    load     = '0;
    load[in_sel] = accept;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    y_out_slot #(
      .SIZE  (SIZE),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (load[i]),
      .din   (in_data),
      .ready (out_ready[i]),
      .valid (out_valid[i]),
      .data  (out_data[i*SIZE +: SIZE])
`ifdef Y_DEMUX_COUNT_EN
      ,.cnt  (cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_y_demux4_router.sv
// Self-checking bench for y_demux4_router: directed scenarios plus random traffic
// checked against a lane-slot reference model.
module tb_y_demux4_router;
  localparam int SIZE = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [SIZE-1:0]   in_data;
  logic [1:0]        in_sel;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [4*SIZE-1:0] out_data;
`ifdef Y_DEMUX_COUNT_EN
  logic [63:0]       cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: what each lane's sink should currently see.
  bit              m_full [4];
  logic [SIZE-1:0] m_word [4];
  logic [15:0]     m_hs   [4];

  y_demux4_router #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef Y_DEMUX_COUNT_EN
    ,.cnt      (cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready();
    return !reset && (!m_full[in_sel] || out_ready[in_sel]);
  endfunction

  // Check outputs mid-cycle, then advance one edge and update the model.
  task automatic cycle();
    bit take;
    #3;
    chk("in_ready", 128'(in_ready), 128'(exp_ready()));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_valid[%0d]", i), 128'(out_valid[i]), 128'(m_full[i]));
      if (m_full[i])
        chk($sformatf("out_data[%0d]", i), 128'(out_data[i*SIZE +: SIZE]), 128'(m_word[i]));
`ifdef Y_DEMUX_COUNT_EN
      chk($sformatf("cnt[%0d]", i), 128'(cnt[i*16 +: 16]), 128'(m_hs[i]));
`endif
    end
    take = in_valid && exp_ready();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_full[i] = 0; m_word[i] = '0; m_hs[i] = '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_full[i] && out_ready[i]) begin
          m_full[i] = 0;
          m_hs[i]   = m_hs[i] + 16'd1;
        end
      end
      if (take) begin
        m_full[in_sel] = 1;
        m_word[in_sel] = in_data;
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [SIZE-1:0] d,
                       input logic [3:0] r);
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 0; m_word[i] = '0; m_hs[i] = '0;
    end

    // Reset held two cycles with a word offered: nothing may be written.
    reset = 1'b1;
    drive(1, 2'd1, 32'hDEADBEEF, 4'b0000);
    cycle();
    cycle();
    chk("reset out_valid", 128'(out_valid), 128'(4'b0000));
    chk("reset out_data", 128'(out_data), 128'(0));
    #3;
    chk("reset in_ready", 128'(in_ready), 128'(1'b0));
    @(negedge clk);
    #2;
    reset = 1'b0;
    drive(0, 2'd0, '0, 4'b0000);
    cycle();

    // Routing, one word per lane on consecutive cycles.
    for (int l = 0; l < 4; l++) begin
      drive(1, 2'(l), {4{4'hA, 4'(l)}}, 4'b1111);
      cycle();
      for (int o = 0; o < 4; o++)
        if (o != l) chk("route other lane idle", 128'(out_valid[o]), 128'(1'b0));
      chk("route word", 128'(out_data[l*SIZE +: SIZE]), 128'({4{4'hA, 4'(l)}}));
    end
    drive(0, 2'd0, '0, 4'b1111);
    cycle();

    // Stall isolation on lane 1.
    drive(1, 2'd1, 32'h12345678, 4'b1101);
    cycle();
    drive(1, 2'd1, 32'h55555555, 4'b1101);
    cycle();
    chk("stall hold", 128'(out_data[1*SIZE +: SIZE]), 128'(32'h12345678));
    #3;
    chk("stall in_ready", 128'(in_ready), 128'(1'b0));
    #2;
    drive(1, 2'd2, 32'h22222222, 4'b1101);
    #1;
    chk("other lane ready", 128'(in_ready), 128'(1'b1));
    cycle();
    chk("lane 2 word", 128'(out_data[2*SIZE +: SIZE]), 128'(32'h22222222));
    drive(0, 2'd0, '0, 4'b1111);
    cycle();

    // Drain and refill lane 0 on the same edge.
    drive(1, 2'd0, 32'h1, 4'b0000);
    cycle();
    drive(1, 2'd0, 32'h2, 4'b0001);
    #1;
    chk("refill in_ready", 128'(in_ready), 128'(1'b1));
    cycle();
    chk("refill valid", 128'(out_valid[0]), 128'(1'b1));
    chk("refill data", 128'(out_data[31:0]), 128'(32'h2));
    drive(0, 2'd0, '0, 4'b0000);
    cycle();

    // Reset mid-operation with lanes 0 and 3 stalled.
    drive(1, 2'd3, 32'h33333333, 4'b0000);
    cycle();
    drive(0, 2'd0, '0, 4'b0000);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("mid reset clears", 128'(out_valid), 128'(4'b0000));
    drive(1, 2'd3, 32'hCAFEF00D, 4'b0000);
    cycle();
    chk("post reset route", 128'(out_data[3*SIZE +: SIZE]), 128'(32'hCAFEF00D));

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom, 4'($urandom));
      cycle();
    end
    reset = 1'b0;

`ifdef Y_DEMUX_COUNT_EN
    // 65537 sink handshakes on lane 2 wrap its counter to 1.
    reset = 1'b1;
    drive(0, 2'd0, '0, 4'b0000);
    cycle();
    reset = 1'b0;
    drive(1, 2'd2, 32'h0, 4'b0100);
    for (int n = 0; n < 65538; n++) begin
      in_data = 32'(n);
      cycle();
    end
    drive(0, 2'd0, '0, 4'b0000);
    #3;
    chk("cnt wrap lane 2", 128'(cnt[2*16 +: 16]), 128'(16'h0001));
    chk("cnt other lanes", 128'({cnt[63:48], cnt[31:0]}), 128'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
